// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings, default baud divisor
// and the start-bit mid-point helper. Also used by uart_tx.
package uart_pkg;

    // System clocks per serial bit at the board's default baud rate.
    localparam int CLKS_PER_BIT_DEFAULT = 87;

    // Receiver FSM states; the remaining 3-bit codes are unused.
    typedef enum logic [2:0] {
        s_IDLE         = 3'd0,
        s_RX_START_BIT = 3'd1,
        s_RX_DATA_BITS = 3'd2,
        s_RX_STOP_BIT  = 3'd3,
        s_CLEANUP      = 3'd4,
        s_BREAK_WAIT   = 3'd5
    } rx_state_t;

    // Count at which the start bit is re-checked at its mid-point.
    function automatic logic [7:0] half_bit_count(input int clks_per_bit);
        return 8'((clks_per_bit - 1) / 2);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input. The reset value is
// a parameter so an idle-high line does not look active coming out of reset.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_Clock,
    input  logic i_Rst_n,
    input  logic i_Async,
    output logic o_Sync
);

    logic meta_reg;

    // Shift the raw input through two flops to settle metastability.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            meta_reg <= RST_VAL;
            o_Sync   <= RST_VAL;
        end else begin
            meta_reg <= i_Async;
            o_Sync   <= meta_reg;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes the RX pin, finds the start edge,
// samples each bit at its mid-point and reports a byte or a framing error.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_Rx_Frame_Err
);

    localparam logic [7:0] HALF_BIT   = half_bit_count(CLKS_PER_BIT);
    localparam logic [7:0] LAST_COUNT = 8'(CLKS_PER_BIT - 1);

    rx_state_t  state_reg;
    logic [7:0] count_reg;
    logic [2:0] bit_index_reg;
    logic [7:0] shift_reg;
    logic       rx_s;

    uart_sync2 #(
        .RST_VAL (1'b1)
    ) u_sync (
        .i_Clock (i_Clock),
        .i_Rst_n (i_Rst_n),
        .i_Async (i_Rx_Serial),
        .o_Sync  (rx_s)
    );

    // Frame FSM: baud counting, bit capture and registered status outputs.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_reg      <= s_IDLE;
            count_reg      <= 8'd0;
            bit_index_reg  <= 3'd0;
            shift_reg      <= 8'd0;
            o_Rx_DV        <= 1'b0;
            o_Rx_Byte      <= 8'd0;
            o_Rx_Active    <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a state raises them below.
            o_Rx_DV        <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
            case (state_reg)
                s_IDLE: begin
                    count_reg     <= 8'd0;
                    bit_index_reg <= 3'd0;
                    if (!rx_s) begin
                        state_reg   <= s_RX_START_BIT;
                        o_Rx_Active <= 1'b1;
                    end
                end
                s_RX_START_BIT: begin
                    if (count_reg == HALF_BIT) begin
                        count_reg <= 8'd0;
                        if (!rx_s) begin
                            state_reg <= s_RX_DATA_BITS;
                        end else begin
                            // Line bounced back high: not a real start bit.
                            state_reg   <= s_IDLE;
                            o_Rx_Active <= 1'b0;
                        end
                    end else begin
                        count_reg <= count_reg + 8'd1;
                    end
                end
                s_RX_DATA_BITS: begin
                    if (count_reg == LAST_COUNT) begin
                        count_reg                <= 8'd0;
                        shift_reg[bit_index_reg] <= rx_s;
                        if (bit_index_reg < 3'd7) begin
                            bit_index_reg <= bit_index_reg + 3'd1;
                        end else begin
                            bit_index_reg <= 3'd0;
                            state_reg     <= s_RX_STOP_BIT;
                        end
                    end else begin
                        count_reg <= count_reg + 8'd1;
                    end
                end
                s_RX_STOP_BIT: begin
                    if (count_reg == LAST_COUNT) begin
                        count_reg   <= 8'd0;
                        o_Rx_Active <= 1'b0;
                        state_reg   <= s_CLEANUP;
                        if (rx_s) begin
                            o_Rx_Byte <= shift_reg;
                            o_Rx_DV   <= 1'b1;
                        end else begin
                            o_Rx_Frame_Err <= 1'b1;
                        end
                    end else begin
                        count_reg <= count_reg + 8'd1;
                    end
                end
                s_CLEANUP: begin
                    // The error strobe is still high here, so it doubles as the
                    // "last frame was bad" flag.
                    state_reg <= o_Rx_Frame_Err ? s_BREAK_WAIT : s_IDLE;
                end
                s_BREAK_WAIT: begin
                    // Hold off until a held-low break releases the line.
                    if (rx_s) begin
                        state_reg <= s_IDLE;
                    end
                end
                default: begin
                    state_reg     <= s_IDLE;
                    count_reg     <= 8'd0;
                    bit_index_reg <= 3'd0;
                    o_Rx_Active   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx at 87 and 4 clocks per bit.
module tb_uart_rx;

    localparam int CPB   = 87;
    localparam int CPB4  = 4;
    localparam int HB    = (CPB - 1) / 2;
    localparam int HB4   = (CPB4 - 1) / 2;
    localparam int STOP_EDGE  = 4 + HB + 9 * CPB;
    localparam int STOP_EDGE4 = 4 + HB4 + 9 * CPB4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       rx4;
    logic       dv, act, err;
    logic [7:0] byt;
    logic       dv4, act4, err4;
    logic [7:0] byt4;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_start = 0;
    int act_cnt = 0;
    int strobe_viol = 0;
    logic prev_dv = 1'b0, prev_err = 1'b0, prev_dv4 = 1'b0, prev_err4 = 1'b0;

    int ev_byte[$];
    int ev_cyc[$];
    int err_cyc[$];
    int ev4_byte[$];
    int ev4_cyc[$];
    int err4_cyc[$];

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock        (clk),
        .i_Rst_n        (rst_n),
        .i_Rx_Serial    (rx),
        .o_Rx_DV        (dv),
        .o_Rx_Byte      (byt),
        .o_Rx_Active    (act),
        .o_Rx_Frame_Err (err)
    );

    uart_rx #(.CLKS_PER_BIT(CPB4)) dut4 (
        .i_Clock        (clk),
        .i_Rst_n        (rst_n),
        .i_Rx_Serial    (rx4),
        .o_Rx_DV        (dv4),
        .o_Rx_Byte      (byt4),
        .o_Rx_Active    (act4),
        .o_Rx_Frame_Err (err4)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Record strobes mid-cycle and flag any strobe protocol violation.
    always @(negedge clk) begin
        if (dv) begin
            ev_byte.push_back(int'(byt));
            ev_cyc.push_back(cyc);
        end
        if (err) err_cyc.push_back(cyc);
        if (dv4) begin
            ev4_byte.push_back(int'(byt4));
            ev4_cyc.push_back(cyc);
        end
        if (err4) err4_cyc.push_back(cyc);
        if (act) act_cnt = act_cnt + 1;
        if ((dv && err) || (dv && prev_dv) || (err && prev_err) ||
            (dv4 && err4) || (dv4 && prev_dv4) || (err4 && prev_err4))
            strobe_viol = strobe_viol + 1;
        prev_dv   = dv;
        prev_err  = err;
        prev_dv4  = dv4;
        prev_err4 = err4;
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int q_at(input int q[$], input int idx);
        if (idx < q.size()) return q[idx];
        return -1;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send87(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        last_start = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            wait_cyc(CPB);
        end
        $display("sent byte %02h stop=%0d at cycle %0d", b, stop_bit, last_start);
    endtask

    task automatic send4(input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        last_start = cyc;
        for (int i = 0; i < 10; i++) begin
            rx4 = frame[i];
            wait_cyc(CPB4);
        end
        $display("sent byte %02h (4 clks/bit) at cycle %0d", b, last_start);
    endtask

    initial begin
        int base, ebase, abase, start;
        int exp_q[$];
        logic [7:0] rb;
        logic [7:0] c3;

        // Reset: outputs must be zero before any clock edge.
        rst_n = 1'b0;
        rx    = 1'b1;
        rx4   = 1'b1;
        #1;
        check("rst_dv", int'(dv), 0);
        check("rst_byte", int'(byt), 0);
        check("rst_active", int'(act), 0);
        check("rst_ferr", int'(err), 0);
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(5);

        // Single frame 0xA5 with exact strobe timing.
        base = ev_byte.size(); ebase = err_cyc.size(); abase = act_cnt;
        send87(8'hA5, 1'b1);
        start = last_start;
        wait_cyc(20);
        check("a5_count", ev_byte.size() - base, 1);
        check("a5_byte", q_at(ev_byte, base), 8'hA5);
        check("a5_dv_edge", q_at(ev_cyc, base) - start, STOP_EDGE);
        check("a5_ferr", err_cyc.size() - ebase, 0);
        check("a5_active_len", act_cnt - abase, STOP_EDGE - 3);
        check("a5_hold", int'(byt), 8'hA5);

        // Back-to-back frames with no idle gap.
        base = ev_byte.size(); ebase = err_cyc.size();
        send87(8'h00, 1'b1);
        send87(8'hFF, 1'b1);
        send87(8'h55, 1'b1);
        wait_cyc(20);
        check("b2b_count", ev_byte.size() - base, 3);
        check("b2b_byte0", q_at(ev_byte, base), 8'h00);
        check("b2b_byte1", q_at(ev_byte, base + 1), 8'hFF);
        check("b2b_byte2", q_at(ev_byte, base + 2), 8'h55);
        check("b2b_ferr", err_cyc.size() - ebase, 0);

        // Short low glitch on an idle line.
        base = ev_byte.size(); ebase = err_cyc.size(); abase = act_cnt;
        rx = 1'b0;
        wait_cyc(20);
        rx = 1'b1;
        wait_cyc(200);
        $display("glitch of 20 cycles applied");
        check("glitch_saw_active", int'(act_cnt > abase), 1);
        check("glitch_active_now", int'(act), 0);
        check("glitch_dv", ev_byte.size() - base, 0);
        check("glitch_ferr", err_cyc.size() - ebase, 0);
        check("glitch_byte", int'(byt), 8'h55);

        // Framing error followed by a long break, then a good frame.
        base = ev_byte.size(); ebase = err_cyc.size();
        send87(8'h3C, 1'b0);
        wait_cyc(2000);
        check("brk_ferr_count", err_cyc.size() - ebase, 1);
        check("brk_dv", ev_byte.size() - base, 0);
        check("brk_active", int'(act), 0);
        check("brk_byte_held", int'(byt), 8'h55);
        rx = 1'b1;
        wait_cyc(2 * CPB);
        send87(8'h81, 1'b1);
        wait_cyc(20);
        check("brk_81_count", ev_byte.size() - base, 1);
        check("brk_81_byte", q_at(ev_byte, base), 8'h81);
        check("brk_ferr_total", err_cyc.size() - ebase, 1);

        // Asynchronous reset during bit 4 of 0xC3, then a clean 0x12.
        base = ev_byte.size(); ebase = err_cyc.size();
        c3 = 8'hC3;
        rx = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = c3[i];
            wait_cyc(CPB);
        end
        rx = c3[4];
        wait_cyc(40);
        #2 rst_n = 1'b0;
        #1;
        $display("reset asserted mid-frame at cycle %0d", cyc);
        check("mid_rst_dv", int'(dv), 0);
        check("mid_rst_byte", int'(byt), 0);
        check("mid_rst_active", int'(act), 0);
        check("mid_rst_ferr", int'(err), 0);
        wait_cyc(3);
        rx    = 1'b1;
        rst_n = 1'b1;
        wait_cyc(200);
        send87(8'h12, 1'b1);
        wait_cyc(20);
        check("rst_12_count", ev_byte.size() - base, 1);
        check("rst_12_byte", q_at(ev_byte, base), 8'h12);
        check("rst_ferr", err_cyc.size() - ebase, 0);

        // Random bytes with random idle gaps against an expected-byte queue.
        base = ev_byte.size(); ebase = err_cyc.size();
        for (int n = 0; n < 6; n++) begin
            rb = 8'($urandom_range(0, 255));
            exp_q.push_back(int'(rb));
            send87(rb, 1'b1);
            wait_cyc(int'($urandom_range(0, 30)));
        end
        wait_cyc(20);
        check("rand_count", ev_byte.size() - base, exp_q.size());
        for (int n = 0; n < exp_q.size(); n++)
            check($sformatf("rand_byte%0d", n), q_at(ev_byte, base + n), exp_q[n]);
        check("rand_ferr", err_cyc.size() - ebase, 0);

        // Minimum divisor: 4 clocks per bit.
        base = ev4_byte.size();
        send4(8'h96);
        start = last_start;
        wait_cyc(10);
        check("c4_count", ev4_byte.size() - base, 1);
        check("c4_byte", q_at(ev4_byte, base), 8'h96);
        check("c4_dv_edge", q_at(ev4_cyc, base) - start, STOP_EDGE4);
        check("c4_ferr", err4_cyc.size(), 0);

        check("strobe_protocol", strobe_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
